// File: rtl/song_sequencer.sv
// Song player: walks note words of the selected song out of an external
// synchronous ROM and drives a passive buzzer with a volume-scaled square wave.
module song_sequencer #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned UNIT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 1_250_000,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned SONG_AW     = 6,
  parameter bit          IDLE_LVL    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       pause,
  input  logic                       loop,
  input  logic [SEL_W-1:0]           song_sel,
  input  logic [1:0]                 volume,
  output logic [SEL_W+SONG_AW-1:0]   rom_addr,
  input  logic [7:0]                 rom_data,
  output logic                       buzzer,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 cur_pitch
);

  localparam int unsigned PER_W = 20;
  localparam int unsigned DUR_W = $clog2(64'd16 * 64'(UNIT_CYCLES));
  localparam int unsigned LEN_W = DUR_W + 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t              state;
  logic [SEL_W-1:0]    song;
  logic [SONG_AW-1:0]  note_idx;
  logic [DUR_W-1:0]    dur_cnt;
  logic [PER_W-1:0]    tone_cnt;
  logic [PER_W-1:0]    period;

  logic [3:0]          rom_pitch_c;
  logic [3:0]          rom_dur_c;
  logic [PER_W-1:0]    period_c;
  logic [LEN_W-1:0]    play_len_c;
  logic [PER_W-1:0]    thresh_c;
  logic                tone_on_c;

  // Tone period in clk cycles for each pitch code; rest and end marker get 0.
  function automatic logic [PER_W-1:0] pitch_period(input logic [3:0] p);
    case (p)
      4'd1:    pitch_period = PER_W'(CLK_HZ / 32'd262);
      4'd2:    pitch_period = PER_W'(CLK_HZ / 32'd294);
      4'd3:    pitch_period = PER_W'(CLK_HZ / 32'd330);
      4'd4:    pitch_period = PER_W'(CLK_HZ / 32'd349);
      4'd5:    pitch_period = PER_W'(CLK_HZ / 32'd392);
      4'd6:    pitch_period = PER_W'(CLK_HZ / 32'd440);
      4'd7:    pitch_period = PER_W'(CLK_HZ / 32'd494);
      4'd8:    pitch_period = PER_W'(CLK_HZ / 32'd523);
      4'd9:    pitch_period = PER_W'(CLK_HZ / 32'd587);
      4'd10:   pitch_period = PER_W'(CLK_HZ / 32'd659);
      4'd11:   pitch_period = PER_W'(CLK_HZ / 32'd698);
      4'd12:   pitch_period = PER_W'(CLK_HZ / 32'd784);
      4'd13:   pitch_period = PER_W'(CLK_HZ / 32'd880);
      4'd14:   pitch_period = PER_W'(CLK_HZ / 32'd988);
      default: pitch_period = '0;
    endcase
  endfunction

  // Note decode: audible portion is (dur+1)*UNIT - GAP cycles, loaded as count-1.
  always_comb begin
    rom_pitch_c = rom_data[7:4];
    rom_dur_c   = rom_data[3:0];
    period_c    = pitch_period(rom_pitch_c);
    play_len_c  = LEN_W'(rom_dur_c) * LEN_W'(UNIT_CYCLES)
                + LEN_W'(UNIT_CYCLES - GAP_CYCLES - 32'd1);
  end

  // Duty threshold: volume 1/2/3 keeps 1/8, 1/4, 1/2 of the period active.
  always_comb begin
    thresh_c = '0;
    case (volume)
      2'd1:    thresh_c = period >> 3;
      2'd2:    thresh_c = period >> 2;
      2'd3:    thresh_c = period >> 1;
      default: thresh_c = '0;
    endcase
    tone_on_c = (cur_pitch != 4'd0) && (tone_cnt < thresh_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      song      <= '0;
      note_idx  <= '0;
      dur_cnt   <= '0;
      tone_cnt  <= '0;
      period    <= '0;
      rom_addr  <= '0;
      buzzer    <= IDLE_LVL;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_pitch <= '0;
    end else begin
      done   <= 1'b0;
      buzzer <= IDLE_LVL;
      if (stop) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        cur_pitch <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              song     <= song_sel;
              note_idx <= '0;
              rom_addr <= {song_sel, SONG_AW'(0)};
              busy     <= 1'b1;
              state    <= S_FETCH;
            end
          end
          S_FETCH: state <= S_DECODE;
          S_DECODE: begin
            if (rom_pitch_c == 4'hF) begin
              if (loop) begin
                note_idx <= '0;
                rom_addr <= {song, SONG_AW'(0)};
                state    <= S_FETCH;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end else begin
              period    <= period_c;
              dur_cnt   <= DUR_W'(play_len_c);
              tone_cnt  <= '0;
              cur_pitch <= rom_pitch_c;
              state     <= S_PLAY;
            end
          end
          // Pause freezes tone phase and duration; buzzer falls silent meanwhile.
          S_PLAY: begin
            if (!pause) begin
              buzzer   <= tone_on_c ? ~IDLE_LVL : IDLE_LVL;
              tone_cnt <= (tone_cnt == period - PER_W'(1)) ? '0 : tone_cnt + PER_W'(1);
              if (dur_cnt == '0) begin
                dur_cnt <= DUR_W'(GAP_CYCLES - 32'd1);
                state   <= S_GAP;
              end else begin
                dur_cnt <= dur_cnt - DUR_W'(1);
              end
            end
          end
          S_GAP: begin
            if (!pause) begin
              if (dur_cnt == '0) begin
                note_idx  <= note_idx + SONG_AW'(1);
                rom_addr  <= {song, note_idx + SONG_AW'(1)};
                cur_pitch <= '0;
                state     <= S_FETCH;
              end else begin
                dur_cnt <= dur_cnt - DUR_W'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboarded bench for song_sequencer: expected ROM address sequence is
// queued per scenario and checked as the sequencer walks the song.
module tb_song_sequencer;

  localparam int unsigned CLK_HZ  = 1_000_000;
  localparam int unsigned UNIT    = 1000;
  localparam int unsigned GAP     = 100;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned SONG_AW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop = 1'b0;
  logic [1:0] song_sel = 2'd0;
  logic [1:0] volume = 2'd0;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic       buzzer;
  logic       busy;
  logic       done;
  logic [3:0] cur_pitch;

  song_sequencer #(
    .CLK_HZ(CLK_HZ), .UNIT_CYCLES(UNIT), .GAP_CYCLES(GAP),
    .SEL_W(SEL_W), .SONG_AW(SONG_AW), .IDLE_LVL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .loop(loop), .song_sel(song_sel), .volume(volume), .rom_addr(rom_addr),
    .rom_data(rom_data), .buzzer(buzzer), .busy(busy), .done(done),
    .cur_pitch(cur_pitch)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [64];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int total = 0;
  int bad = 0;

  // Scoreboard monitor state
  logic [5:0] addr_q[$];
  logic [5:0] prev_addr = 6'd0;
  logic [5:0] mon_exp;
  int cyc = 0;
  int last_chg = 0;
  int interval = 0;
  int low_acc = 0;
  int note_low = 0;
  int done_cnt = 0;
  logic busy_prev = 1'b0;
  logic busy_at_done = 1'b0;
  logic busy_before_done = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_addr = rom_addr;
      low_acc   = 0;
      busy_prev = 1'b0;
    end else begin
      if (rom_addr !== prev_addr) begin
        interval = cyc - last_chg;
        last_chg = cyc;
        note_low = low_acc;
        low_acc  = 0;
        total++;
        if (addr_q.size() == 0) begin
          bad++;
          $display("FAIL rom_addr_seq: got %h, none expected", rom_addr);
        end else begin
          mon_exp = addr_q.pop_front();
          if (rom_addr !== mon_exp) begin
            bad++;
            $display("FAIL rom_addr_seq: got %h, expected %h", rom_addr, mon_exp);
          end
        end
        prev_addr = rom_addr;
      end
      if (buzzer === 1'b0) low_acc++;
      if (done === 1'b1) begin
        done_cnt++;
        busy_at_done     = busy;
        busy_before_done = busy_prev;
      end
      busy_prev = busy;
    end
  end

  // Reference count of active-level cycles for a freshly started tone.
  function automatic int count_low(int len, int per, int thr);
    int n = 0;
    for (int c = 0; c < len; c++) if ((c % per) < thr) n++;
    return n;
  endfunction

  function automatic int thresh(int per, int vol);
    return (vol == 0) ? 0 : (per >> (4 - vol));
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_q(int n, int limit, string name);
    int k = 0;
    while (addr_q.size() > n && k < limit) begin
      tick(1);
      k++;
    end
    total++;
    if (addr_q.size() > n) begin
      bad++;
      $display("FAIL %s timeout: queue=%0d expected<=%0d", name, addr_q.size(), n);
    end
  endtask

  task automatic load_song1();
    rom[6'h10] = 8'h63;
    rom[6'h11] = 8'hF0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total += 5;
    if (buzzer !== 1'b1) begin bad++; $display("FAIL reset_buzzer: got %b, expected 1", buzzer); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b, expected 0", done); end
    if (rom_addr !== 6'h00) begin bad++; $display("FAIL reset_addr: got %h, expected 00", rom_addr); end
    if (cur_pitch !== 4'd0) begin bad++; $display("FAIL reset_pitch: got %0d, expected 0", cur_pitch); end
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_tone_volume(int vol);
    int per = CLK_HZ / 440;
    int exp_low = count_low(4 * UNIT - GAP, per, thresh(per, vol));
    load_song1();
    volume = 2'(vol); loop = 1'b0; song_sel = 2'd1;
    done_cnt = 0;
    addr_q.push_back(6'h10);
    addr_q.push_back(6'h11);
    pulse_start();
    wait_q(1, 50, "tone_first_fetch");
    tick(10);
    total += 2;
    if (cur_pitch !== 4'd6) begin bad++; $display("FAIL tone_pitch vol%0d: got %0d, expected 6", vol, cur_pitch); end
    if (busy !== 1'b1) begin bad++; $display("FAIL tone_busy vol%0d: got %b, expected 1", vol, busy); end
    wait_q(0, 4100, "tone_end_fetch");
    total += 2;
    if (interval !== 4 * UNIT + 2) begin bad++; $display("FAIL tone_len vol%0d: got %0d, expected %0d", vol, interval, 4 * UNIT + 2); end
    if (note_low !== exp_low) begin bad++; $display("FAIL tone_duty vol%0d: got %0d, expected %0d", vol, note_low, exp_low); end
    tick(5);
    total += 4;
    if (done_cnt !== 1) begin bad++; $display("FAIL tone_done vol%0d: got %0d, expected 1", vol, done_cnt); end
    if (busy_at_done !== 1'b0) begin bad++; $display("FAIL tone_busy_at_done vol%0d: got %b, expected 0", vol, busy_at_done); end
    if (busy_before_done !== 1'b1) begin bad++; $display("FAIL tone_busy_before_done vol%0d: got %b, expected 1", vol, busy_before_done); end
    if (busy !== 1'b0) begin bad++; $display("FAIL tone_idle vol%0d: got %b, expected 0", vol, busy); end
  endtask

  task automatic test_pause();
    int per = CLK_HZ / 440;
    int exp_low = count_low(4 * UNIT - GAP, per, thresh(per, 3));
    load_song1();
    volume = 2'd3; loop = 1'b0; song_sel = 2'd1;
    done_cnt = 0;
    addr_q.push_back(6'h10);
    addr_q.push_back(6'h11);
    pulse_start();
    wait_q(1, 50, "pause_first_fetch");
    tick(500);
    pause = 1'b1;
    tick(1500);
    total += 2;
    if (buzzer !== 1'b1) begin bad++; $display("FAIL pause_buzzer: got %b, expected 1", buzzer); end
    if (cur_pitch !== 4'd6) begin bad++; $display("FAIL pause_pitch: got %0d, expected 6", cur_pitch); end
    tick(1500);
    pause = 1'b0;
    wait_q(0, 4100, "pause_end_fetch");
    total += 2;
    if (interval !== 4 * UNIT + 2 + 3000) begin bad++; $display("FAIL pause_len: got %0d, expected %0d", interval, 4 * UNIT + 2 + 3000); end
    if (note_low !== exp_low) begin bad++; $display("FAIL pause_phase: got %0d, expected %0d", note_low, exp_low); end
    tick(5);
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL pause_done: got %0d, expected 1", done_cnt); end
  endtask

  task automatic test_loop();
    int per = CLK_HZ / 262;
    rom[6'h00] = 8'h10;
    rom[6'h01] = 8'h00;
    rom[6'h02] = 8'hF0;
    volume = 2'd3; loop = 1'b1; song_sel = 2'd0;
    done_cnt = 0;
    addr_q.push_back(6'h00);
    addr_q.push_back(6'h01);
    addr_q.push_back(6'h02);
    addr_q.push_back(6'h00);
    pulse_start();
    wait_q(3, 50, "loop_first_fetch");
    wait_q(2, 1100, "loop_rest_fetch");
    total += 2;
    if (interval !== UNIT + 2) begin bad++; $display("FAIL loop_c4_len: got %0d, expected %0d", interval, UNIT + 2); end
    if (note_low !== count_low(UNIT - GAP, per, thresh(per, 3))) begin
      bad++; $display("FAIL loop_c4_duty: got %0d, expected %0d", note_low, count_low(UNIT - GAP, per, thresh(per, 3)));
    end
    tick(500);
    total++;
    if (buzzer !== 1'b1) begin bad++; $display("FAIL loop_rest_buzzer: got %b, expected 1", buzzer); end
    wait_q(1, 1100, "loop_end_fetch");
    total += 2;
    if (interval !== UNIT + 2) begin bad++; $display("FAIL loop_rest_len: got %0d, expected %0d", interval, UNIT + 2); end
    if (note_low !== 0) begin bad++; $display("FAIL loop_rest_duty: got %0d, expected 0", note_low); end
    wait_q(0, 50, "loop_wrap_fetch");
    total += 3;
    if (interval !== 2) begin bad++; $display("FAIL loop_restart_len: got %0d, expected 2", interval); end
    if (done_cnt !== 0) begin bad++; $display("FAIL loop_no_done: got %0d, expected 0", done_cnt); end
    if (busy !== 1'b1) begin bad++; $display("FAIL loop_busy: got %b, expected 1", busy); end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(1);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL loop_stop_busy: got %b, expected 0", busy); end
    loop = 1'b0;
  endtask

  task automatic test_stop_start();
    load_song1();
    volume = 2'd3; loop = 1'b0; song_sel = 2'd1;
    done_cnt = 0;
    addr_q.push_back(6'h10);
    pulse_start();
    wait_q(0, 50, "stop_first_fetch");
    tick(500);
    song_sel = 2'd2;
    pulse_start();
    tick(5);
    total += 3;
    if (rom_addr !== 6'h10) begin bad++; $display("FAIL busy_start_addr: got %h, expected 10", rom_addr); end
    if (cur_pitch !== 4'd6) begin bad++; $display("FAIL busy_start_pitch: got %0d, expected 6", cur_pitch); end
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_start_busy: got %b, expected 1", busy); end
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy: got %b, expected 0", busy); end
    if (buzzer !== 1'b1) begin bad++; $display("FAIL stop_buzzer: got %b, expected 1", buzzer); end
    if (cur_pitch !== 4'd0) begin bad++; $display("FAIL stop_pitch: got %0d, expected 0", cur_pitch); end
    tick(20);
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL stop_no_restart: got %b, expected 0", busy); end
    if (done_cnt !== 0) begin bad++; $display("FAIL stop_no_done: got %0d, expected 0", done_cnt); end
    if (rom_addr !== 6'h10) begin bad++; $display("FAIL stop_addr: got %h, expected 10", rom_addr); end
  endtask

  task automatic test_wrap_and_reset();
    for (int i = 0; i < 16; i++) rom[6'h30 + i] = {4'(1 + i % 14), 4'h0};
    volume = 2'd2; loop = 1'b0; song_sel = 2'd3;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) addr_q.push_back(6'(6'h30 + i));
    addr_q.push_back(6'h30);
    pulse_start();
    wait_q(0, 17 * (UNIT + 2) + 100, "wrap_fetch");
    total += 3;
    if (interval !== UNIT + 2) begin bad++; $display("FAIL wrap_len: got %0d, expected %0d", interval, UNIT + 2); end
    if (done_cnt !== 0) begin bad++; $display("FAIL wrap_no_done: got %0d, expected 0", done_cnt); end
    if (busy !== 1'b1) begin bad++; $display("FAIL wrap_busy: got %b, expected 1", busy); end
    tick(300);
    rst_n = 1'b0;
    #3;
    total += 5;
    if (buzzer !== 1'b1) begin bad++; $display("FAIL midreset_buzzer: got %b, expected 1", buzzer); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL midreset_done: got %b, expected 0", done); end
    if (rom_addr !== 6'h00) begin bad++; $display("FAIL midreset_addr: got %h, expected 00", rom_addr); end
    if (cur_pitch !== 4'd0) begin bad++; $display("FAIL midreset_pitch: got %0d, expected 0", cur_pitch); end
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'hF0;
    test_reset();
    test_tone_volume(3);
    test_tone_volume(1);
    test_tone_volume(0);
    test_pause();
    test_loop();
    test_stop_start();
    test_wrap_and_reset();
    total++;
    if (addr_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", addr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Parametrised successor to the fixed two-song buzzer player.
- Fetches note words for one of NUM_SONGS songs from an external synchronous ROM and generates a square wave for a passive buzzer.
- Adds note-length encoding, articulation gap, loop/one-shot mode, pause, stop and a 4-level volume (duty) control.
- Sits between the song ROM, the board switches/buttons (already debounced, start/stop as 1-cycle pulses) and the buzzer pin.

Parameters:
- CLK_HZ, 100_000_000: clk frequency; tone periods are CLK_HZ/freq (integer division, elaboration-time constants). Legal range CLK_HZ ≤ 274_000_000.
- UNIT_CYCLES, 12_500_000: clk cycles per duration unit (1/8 s at default).
- GAP_CYCLES, 1_250_000: silent tail of every note. Must satisfy 0 < GAP_CYCLES < UNIT_CYCLES.
- SEL_W, 2: song select width; NUM_SONGS = 2**SEL_W.
- SONG_AW, 6: note-index width; max 2**SONG_AW words per song.
- IDLE_LVL, 1: buzzer level when silent (1 = active-low buzzer).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begin song_sel (ignored while busy)
- stop  in  1  pulse; abort playback
- pause  in  1  level; freeze playback while high
- loop  in  1  level; restart song at end marker instead of finishing
- song_sel  in  SEL_W  song to play, sampled on accepted start
- volume  in  2  0 = mute, 1/2/3 = 12.5/25/50 % duty
- rom_addr  out  SEL_W+SONG_AW  = {song, note_idx}, registered
- rom_data  in  8  {pitch[7:4], dur[3:0]}, valid 1 cycle after rom_addr changes
- buzzer  out  1  tone output, registered
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  1-cycle pulse on natural song end (not on stop)
- cur_pitch  out  4  pitch of the note in PLAY/GAP, else 0

Behaviour:
- Reset values:
  - buzzer = IDLE_LVL; busy, done, rom_addr, cur_pitch = 0; state = IDLE.
- Pitch codes:
  - 0 = rest.
  - 1..7 = C4 D4 E4 F4 G4 A4 B4 (262 294 330 349 392 440 494 Hz).
  - 8..14 = C5..B5 (523 587 659 698 784 880 988 Hz).
  - 15 = end marker.
- Note length: (dur+1)*UNIT_CYCLES total = PLAY for (dur+1)*UNIT_CYCLES − GAP_CYCLES, then GAP for GAP_CYCLES.
- FSM states: IDLE, FETCH, DECODE, PLAY, GAP.
  - IDLE: on start (and not stop) latch song_sel, note_idx = 0, busy = 1 → FETCH.
  - FETCH: one cycle for ROM latency → DECODE.
  - DECODE, pitch 15: if loop, note_idx = 0 → FETCH; else done = 1 → IDLE.
  - DECODE, other pitch: load period and duration counter, reset tone counter → PLAY. cur_pitch = pitch.
  - PLAY: when duration counter expires → GAP.
  - GAP: on expiry, note_idx + 1 → FETCH. note_idx wraps 2**SONG_AW−1 → 0 within the same song.
- Tone generation (PLAY only, pitch ≠ 0):
  - Tone counter runs 0..period−1 and wraps.
  - buzzer = ~IDLE_LVL while count < (period >> (4 − volume)), else IDLE_LVL.
  - volume 0, rest notes, GAP, FETCH, DECODE and IDLE all drive buzzer = IDLE_LVL.
  - volume is sampled every cycle.
- Pause: while high in PLAY/GAP, the duration, gap and tone counters hold and buzzer = IDLE_LVL. On release, resume exactly where frozen. Pause has no effect in FETCH/DECODE (they complete), but the FSM holds on entering PLAY.
- Stop: from any state, next cycle → IDLE; busy = 0, cur_pitch = 0, buzzer = IDLE_LVL, no done. stop and start in the same cycle: stop wins, nothing starts.
- start while busy is ignored; song_sel changes while busy are ignored.
- Reset mid-song: immediate return to reset values.
- Widths:
  - Duration counter ≥ clog2(16*UNIT_CYCLES).
  - Period 20 bits.
  - No overflow permitted for legal parameters.

Test Plan (CLK_HZ=1_000_000, UNIT_CYCLES=20_000, GAP_CYCLES=2_000, SEL_W=2, SONG_AW=4):
- Song 1 ROM = {0x61, 0xF0}, loop = 0, volume = 3, start:
  - rom_addr = 0x10 then 0x11.
  - A4 period 2272: buzzer low 1136 / high 1136 cycles for 38_000 cycles, then 2_000 high.
  - done pulses once; busy falls the same cycle.
- Same song, volume = 1: low time 284 of 2272 per period; volume = 0: buzzer constantly 1 with timing unchanged.
- Song 0 = {0x10, 0x00, 0xF0}, loop = 1:
  - After the end marker rom_addr returns to 0x00 without a done pulse.
  - Rest note holds buzzer = 1 for 18_000 + 2_000 cycles.
- Pause asserted 10_000 cycles into a 38_000-cycle PLAY for 50_000 cycles: total note time 90_000 cycles; the tone phase continues from its frozen count.
- stop and start both pulsed mid-note: next cycle busy = 0, buzzer = 1, no done; start pulsed while busy: no change to rom_addr or song.
- Song 3 with 16 non-end words, loop = 0: note_idx wraps 15 → 0 and rom_addr = 0x30 again; rst_n low mid-note forces all outputs to reset values asynchronously.
